// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V subset control FSM: fetch/decode/execute/memory/write-back
// sequencing with memory-handshake timeout and sticky fault reporting.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_sel,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       alu_src_imm,
  output logic [5:0] alu_op,
  output logic [2:0] state,
  output logic       retire,
  output logic [1:0] fault
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [2:0] K_ALU   = 3'd0;
  localparam logic [2:0] K_LOAD  = 3'd1;
  localparam logic [2:0] K_STORE = 3'd2;
  localparam logic [2:0] K_BR    = 3'd3;
  localparam logic [2:0] K_JAL   = 3'd4;

  localparam logic [5:0] OP_ADD  = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_SLL  = 6'b000011;
  localparam logic [5:0] OP_JAL  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b000101;
  localparam logic [5:0] OP_AND  = 6'b000110;
  localparam logic [5:0] OP_OR   = 6'b000111;
  localparam logic [5:0] OP_XOR  = 6'b001000;
  localparam logic [5:0] OP_BLT  = 6'b001001;
  localparam logic [5:0] OP_BEQ  = 6'b001010;
  localparam logic [5:0] OP_SRL  = 6'b001011;
  localparam logic [5:0] OP_LW   = 6'b001100;
  localparam logic [5:0] OP_SW   = 6'b001101;

  localparam int CW = $clog2(TIMEOUT + 2);

  logic [2:0]    state_r, state_nxt_s;
  logic [1:0]    fault_r, fault_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
  logic          started_r;
  logic [2:0]    kind_r, kind_dec_s;
  logic [5:0]    op_r, op_dec_s;
  logic          imm_r, imm_dec_s, illegal_s;
  logic          req_s, ack_s, wait_s, hit_s, taken_s;

  // Instruction classification from the IR fields
  always_comb begin
    illegal_s  = 1'b0;
    kind_dec_s = K_ALU;
    op_dec_s   = 6'b000000;
    imm_dec_s  = 1'b0;
    case (opcode)
      7'b0110011: begin
        case ({funct7b5, funct3})
          4'b0000: op_dec_s = OP_ADD;
          4'b1000: op_dec_s = OP_SUB;
          4'b0001: op_dec_s = OP_SLL;
          4'b0111: op_dec_s = OP_AND;
          4'b0110: op_dec_s = OP_OR;
          4'b0100: op_dec_s = OP_XOR;
          4'b0101: op_dec_s = OP_SRL;
          default: illegal_s = 1'b1;
        endcase
      end
      7'b0010011: begin
        op_dec_s  = OP_ADDI;
        imm_dec_s = 1'b1;
        if (funct3 != 3'b000) illegal_s = 1'b1;
        else                  illegal_s = 1'b0;
      end
      7'b0000011: begin
        kind_dec_s = K_LOAD;
        op_dec_s   = OP_LW;
        imm_dec_s  = 1'b1;
        if (funct3 != 3'b010) illegal_s = 1'b1;
        else                  illegal_s = 1'b0;
      end
      7'b0100011: begin
        kind_dec_s = K_STORE;
        op_dec_s   = OP_SW;
        imm_dec_s  = 1'b1;
        if (funct3 != 3'b010) illegal_s = 1'b1;
        else                  illegal_s = 1'b0;
      end
      7'b1100011: begin
        kind_dec_s = K_BR;
        case (funct3)
          3'b000:  op_dec_s = OP_BEQ;
          3'b100:  op_dec_s = OP_BLT;
          default: illegal_s = 1'b1;
        endcase
      end
      7'b1101111: begin
        kind_dec_s = K_JAL;
        op_dec_s   = OP_JAL;
      end
      default: illegal_s = 1'b1;
    endcase
  end

  // A request is live only once the first post-reset edge has passed
  assign req_s     = started_r && ((state_r == S_FETCH) || (state_r == S_MEM));
  assign ack_s     = req_s && mem_ack;
  assign wait_s    = req_s && !mem_ack;
  assign cnt_inc_s = cnt_r + CW'(1);
  assign hit_s     = (TIMEOUT != 0) && wait_s && (cnt_inc_s == CW'(TIMEOUT));
  assign taken_s   = ((op_r == OP_BEQ) && alu_zero) || ((op_r == OP_BLT) && alu_lt);

  // Wait counter: advances per unanswered request cycle, clears otherwise
  always_comb begin
    if (wait_s && (TIMEOUT != 0) && !hit_s) cnt_nxt_s = cnt_inc_s;
    else                                     cnt_nxt_s = '0;
  end

  // Next-state and strobe decode
  always_comb begin
    state_nxt_s = state_r;
    fault_nxt_s = fault_r;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 1'b0;
    rf_we       = 1'b0;
    wb_sel      = 2'd0;
    alu_src_imm = 1'b0;
    alu_op      = 6'b000000;
    retire      = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_req = req_s;
        if (ack_s) begin
          ir_we       = 1'b1;
          state_nxt_s = S_DECODE;
        end else if (hit_s) begin
          state_nxt_s = S_HALT;
          fault_nxt_s = 2'd2;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_DECODE: begin
        if (illegal_s) begin
          state_nxt_s = S_HALT;
          fault_nxt_s = 2'd1;
        end else begin
          state_nxt_s = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op      = op_r;
        alu_src_imm = imm_r;
        case (kind_r)
          K_BR: begin
            pc_we       = 1'b1;
            pc_sel      = taken_s;
            retire      = 1'b1;
            state_nxt_s = S_FETCH;
          end
          K_LOAD, K_STORE: state_nxt_s = S_MEM;
          K_ALU, K_JAL:    state_nxt_s = S_WB;
          default: begin
            state_nxt_s = S_HALT;
            fault_nxt_s = 2'd1;
          end
        endcase
      end
      S_MEM: begin
        mem_req     = req_s;
        mem_we      = req_s && (kind_r == K_STORE);
        alu_op      = op_r;
        alu_src_imm = imm_r;
        if (ack_s) begin
          if (kind_r == K_STORE) begin
            pc_we       = 1'b1;
            retire      = 1'b1;
            state_nxt_s = S_FETCH;
          end else begin
            state_nxt_s = S_WB;
          end
        end else if (hit_s) begin
          state_nxt_s = S_HALT;
          fault_nxt_s = 2'd2;
        end else begin
          state_nxt_s = S_MEM;
        end
      end
      S_WB: begin
        rf_we       = 1'b1;
        pc_we       = 1'b1;
        retire      = 1'b1;
        state_nxt_s = S_FETCH;
        if (kind_r == K_LOAD)     wb_sel = 2'd1;
        else if (kind_r == K_JAL) wb_sel = 2'd2;
        else                      wb_sel = 2'd0;
        if (kind_r == K_JAL) pc_sel = 1'b1;
        else                 pc_sel = 1'b0;
      end
      S_HALT: state_nxt_s = S_HALT;
      default: begin
        state_nxt_s = S_HALT;
        fault_nxt_s = 2'd1;
      end
    endcase
  end

  // Sequential state, fault, counter and decoded-instruction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_FETCH;
      fault_r   <= 2'd0;
      cnt_r     <= '0;
      started_r <= 1'b0;
      kind_r    <= K_ALU;
      op_r      <= 6'b000000;
      imm_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      fault_r   <= fault_nxt_s;
      cnt_r     <= cnt_nxt_s;
      started_r <= 1'b1;
      if ((state_r == S_DECODE) && !illegal_s) begin
        kind_r <= kind_dec_s;
        op_r   <= op_dec_s;
        imm_r  <= imm_dec_s;
      end
    end
  end

  assign state = state_r;
  assign fault = fault_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed vector table, corner-case
// sequences and random instructions against an instruction-level trace model.
module tb_multicycle_ctrl;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n, alu_zero, alu_lt, mem_ack, funct7b5;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic mem_req, mem_we, ir_we, pc_we, pc_sel, rf_we, alu_src_imm, retire;
  logic [1:0] wb_sel, fault;
  logic [5:0] alu_op;
  logic [2:0] state;

  multicycle_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .mem_ack(mem_ack), .mem_req(mem_req),
    .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
    .wb_sel(wb_sel), .alu_src_imm(alu_src_imm), .alu_op(alu_op), .state(state),
    .retire(retire), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef enum int {K_ALU, K_LOAD, K_STORE, K_BR, K_JAL, K_ILL} kind_e;
  typedef struct {
    logic [31:0] instr; logic zero; logic lt; int d_f; int d_m;
    kind_e kind; logic [5:0] op; logic imm; logic taken;
  } vec_t;
  typedef struct {
    logic ack; logic [2:0] st; logic req, we, irw, pcw, pcs, rfw;
    logic [1:0] wbs; logic imm; logic [5:0] op; logic ret; logic [1:0] flt;
  } cyc_t;

  localparam logic [5:0] ADD = 6'b000001, SUB = 6'b000010, SLL = 6'b000011, JAL = 6'b000100;
  localparam logic [5:0] ADDI = 6'b000101, AND = 6'b000110, OR = 6'b000111, XOR = 6'b001000;
  localparam logic [5:0] BLT = 6'b001001, BEQ = 6'b001010, SRL = 6'b001011, LW = 6'b001100;
  localparam logic [5:0] SW = 6'b001101;

  cyc_t q[$];
  int errors = 0, checks = 0;
  logic [1:0] mflt = 2'd0;
  bit halted = 1'b0;
  int halt_len = 4;

  function automatic cyc_t mk(logic [2:0] st);
    cyc_t c;
    c.ack = 1'($urandom_range(0, 1));
    c.st = st; c.req = 1'b0; c.we = 1'b0; c.irw = 1'b0; c.pcw = 1'b0; c.pcs = 1'b0;
    c.rfw = 1'b0; c.wbs = 2'd0; c.imm = 1'b0; c.op = 6'd0; c.ret = 1'b0; c.flt = mflt;
    return c;
  endfunction

  function automatic void halt_cycles();
    halted = 1'b1;
    for (int i = 0; i < halt_len; i++) q.push_back(mk(3'd5));
  endfunction

  // Expected per-cycle trace of one instruction, derived from its profile
  function automatic void build(vec_t v);
    cyc_t c;
    c = mk(3'd0); c.req = 1'b1; c.ack = 1'b0;
    for (int i = 0; i < v.d_f && i < TO; i++) q.push_back(c);
    if (v.d_f >= TO) begin mflt = 2'd2; halt_cycles(); return; end
    c.ack = 1'b1; c.irw = 1'b1; q.push_back(c);
    q.push_back(mk(3'd1));
    if (v.kind == K_ILL) begin mflt = 2'd1; halt_cycles(); return; end
    c = mk(3'd2); c.op = v.op; c.imm = v.imm;
    if (v.kind == K_BR) begin
      c.pcw = 1'b1; c.pcs = v.taken; c.ret = 1'b1; q.push_back(c); return;
    end
    q.push_back(c);
    if (v.kind == K_LOAD || v.kind == K_STORE) begin
      c = mk(3'd3); c.req = 1'b1; c.we = (v.kind == K_STORE); c.op = v.op; c.imm = v.imm; c.ack = 1'b0;
      for (int i = 0; i < v.d_m && i < TO; i++) q.push_back(c);
      if (v.d_m >= TO) begin mflt = 2'd2; halt_cycles(); return; end
      c.ack = 1'b1;
      if (v.kind == K_STORE) begin c.pcw = 1'b1; c.ret = 1'b1; q.push_back(c); return; end
      q.push_back(c);
    end
    c = mk(3'd4); c.rfw = 1'b1; c.pcw = 1'b1; c.ret = 1'b1; c.pcs = (v.kind == K_JAL);
    c.wbs = (v.kind == K_LOAD) ? 2'd1 : ((v.kind == K_JAL) ? 2'd2 : 2'd0);
    q.push_back(c);
  endfunction

  // Reference decode straight from the instruction-set rules
  function automatic vec_t ref_model(logic [31:0] ins, logic z, logic l, int df, int dm);
    vec_t v;
    logic [2:0] f3;
    f3 = ins[14:12];
    v.instr = ins; v.zero = z; v.lt = l; v.d_f = df; v.d_m = dm;
    v.kind = K_ILL; v.op = 6'd0; v.imm = 1'b0; v.taken = 1'b0;
    case (ins[6:0])
      7'b0110011: begin
        v.kind = K_ALU;
        case (f3)
          3'd0: v.op = ins[30] ? SUB : ADD;
          3'd1: v.op = SLL;
          3'd4: v.op = XOR;
          3'd5: v.op = SRL;
          3'd6: v.op = OR;
          3'd7: v.op = AND;
          default: v.kind = K_ILL;
        endcase
      end
      7'b0010011: if (f3 == 3'd0) begin v.kind = K_ALU; v.op = ADDI; v.imm = 1'b1; end
      7'b0000011: if (f3 == 3'd2) begin v.kind = K_LOAD; v.op = LW; v.imm = 1'b1; end
      7'b0100011: if (f3 == 3'd2) begin v.kind = K_STORE; v.op = SW; v.imm = 1'b1; end
      7'b1100011: begin
        if (f3 == 3'd0) begin v.kind = K_BR; v.op = BEQ; v.taken = z; end
        if (f3 == 3'd4) begin v.kind = K_BR; v.op = BLT; v.taken = l; end
      end
      7'b1101111: begin v.kind = K_JAL; v.op = JAL; end
      default: v.kind = K_ILL;
    endcase
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_cyc(input string name, input cyc_t c);
    logic [21:0] act, exp, mask;
    exp = {c.st, c.req, c.we, c.irw, c.pcw, c.pcs, c.rfw, c.wbs, c.imm, c.op, c.ret, c.flt};
    act = {state, mem_req, mem_we, ir_we, pc_we, pc_sel, rf_we, wb_sel, alu_src_imm, alu_op, retire, fault};
    mask = {3'b111, 1'b1, c.req, 1'b1, 1'b1, c.pcw, 1'b1, {2{c.rfw}}, (c.st == 3'd2), 6'h3f, 1'b1, 2'b11};
    checks++;
    if ((act & mask) !== (exp & mask)) begin
      errors++;
      $display("FAIL %s st=%0d: got %h want %h (mask %h) {st,req,we,ir,pcw,pcs,rfw,wb,imm,op,ret,flt}",
               name, c.st, act & mask, exp & mask, mask);
    end
  endtask

  // Called at a falling edge; applies one cycle and checks before the rising edge
  task automatic run_one(input string name);
    cyc_t c;
    c = q.pop_front();
    mem_ack = c.ack;
    #2;
    check_cyc(name, c);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_q(input string name);
    while (q.size() > 0) run_one(name);
    mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    cyc_t c;
    rst_n = 1'b0;
    #1;
    chk("rst_async", {15'd0, state, fault, mem_req, mem_we, ir_we, pc_we, rf_we, retire, alu_op}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; mflt = 2'd0; halted = 1'b0; q.delete();
    c = mk(3'd0); c.ack = 1'b1;
    q.push_back(c);
    run_q("prestart");
  endtask

  task automatic set_instr(input vec_t v);
    opcode = v.instr[6:0]; funct3 = v.instr[14:12]; funct7b5 = v.instr[30];
    alu_zero = v.zero; alu_lt = v.lt;
  endtask

  task automatic run_vec(input string name, input vec_t v);
    set_instr(v);
    build(v);
    run_q(name);
    if (halted) begin #3; do_reset(); end
  endtask

  vec_t tbl[16];
  vec_t v;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mem_ack = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    alu_zero = 1'b0; alu_lt = 1'b0;
    @(negedge clk);
    #2;
    chk("reset_state", {29'd0, state}, 32'd0);
    chk("reset_req_fault", {29'd0, mem_req, fault}, 32'd0);
    #1;
    do_reset();

    //          instr         z     lt    d_f d_m kind     op    imm   taken
    tbl[0]  = '{32'h002081B3, 1'b0, 1'b0, 2, 0, K_ALU,   ADD,  1'b0, 1'b0};
    tbl[1]  = '{32'h40208233, 1'b0, 1'b0, 0, 0, K_ALU,   SUB,  1'b0, 1'b0};
    tbl[2]  = '{32'h00508093, 1'b0, 1'b0, 1, 0, K_ALU,   ADDI, 1'b1, 1'b0};
    tbl[3]  = '{32'h00208463, 1'b1, 1'b0, 0, 0, K_BR,    BEQ,  1'b0, 1'b1};
    tbl[4]  = '{32'h00208463, 1'b0, 1'b1, 1, 0, K_BR,    BEQ,  1'b0, 1'b0};
    tbl[5]  = '{32'h0020C463, 1'b0, 1'b1, 0, 0, K_BR,    BLT,  1'b0, 1'b1};
    tbl[6]  = '{32'h0000A103, 1'b0, 1'b0, 3, 3, K_LOAD,  LW,   1'b1, 1'b0};
    tbl[7]  = '{32'h0020A023, 1'b0, 1'b0, 3, 3, K_STORE, SW,   1'b1, 1'b0};
    tbl[8]  = '{32'h008000EF, 1'b0, 1'b0, 0, 0, K_JAL,   JAL,  1'b0, 1'b0};
    tbl[9]  = '{32'h0020C1B3, 1'b0, 1'b0, 0, 0, K_ALU,   XOR,  1'b0, 1'b0};
    tbl[10] = '{32'h0020D1B3, 1'b0, 1'b0, 0, 0, K_ALU,   SRL,  1'b0, 1'b0};
    tbl[11] = '{32'h00000000, 1'b0, 1'b0, 0, 0, K_ILL,   6'd0, 1'b0, 1'b0};
    tbl[12] = '{32'h00109093, 1'b0, 1'b0, 0, 0, K_ILL,   6'd0, 1'b0, 1'b0};
    tbl[13] = '{32'h00008103, 1'b0, 1'b0, 0, 0, K_ILL,   6'd0, 1'b0, 1'b0};
    tbl[14] = '{32'h002081B3, 1'b0, 1'b0, 4, 0, K_ALU,   ADD,  1'b0, 1'b0};
    tbl[15] = '{32'h0020A023, 1'b0, 1'b0, 0, 4, K_STORE, SW,   1'b1, 1'b0};

    for (int i = 0; i < 16; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Illegal opcode: HALT must stay silent for 20 cycles despite ack pulses
    halt_len = 20;
    run_vec("halt20", tbl[11]);
    halt_len = 4;

    // Reset dropped between edges while a load is waiting in MEM
    v = tbl[6];
    set_instr(v);
    build(v);
    while (q.size() > 0 && q[0].st != 3'd3) run_one("mid_mem");
    begin
      cyc_t c;
      c = q.pop_front();
      mem_ack = 1'b0;
      #2;
      check_cyc("mid_mem_wait", c);
      #1;
      do_reset();
    end
    run_vec("after_reset_add", tbl[0]);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] ins;
      int df, dm;
      ins = $urandom;
      case ($urandom_range(0, 7))
        0: begin ins[6:0] = 7'b0110011; if (ins[14:12] != 3'd0) ins[30] = 1'b0; end
        1: ins[6:0] = 7'b0010011;
        2: begin ins[6:0] = 7'b0000011; if ($urandom_range(0, 1) == 1) ins[14:12] = 3'b010; end
        3: begin ins[6:0] = 7'b0100011; if ($urandom_range(0, 1) == 1) ins[14:12] = 3'b010; end
        4: ins[6:0] = 7'b1100011;
        5: ins[6:0] = 7'b1101111;
        6: ins[6:0] = 7'b0110011;
        default: ;
      endcase
      if (ins[6:0] == 7'b0110011 && ins[14:12] != 3'd0) ins[30] = 1'b0;
      df = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, TO - 1);
      dm = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, TO - 1);
      v = ref_model(ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), df, dm);
      run_vec($sformatf("rand%0d", n), v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum cycles mem_req may wait for mem_ack; 0 disables the timeout.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous reset, active-low.
REQ-004 SHALL have port opcode, input, 7: instr[6:0] from the datapath IR.
REQ-005 SHALL have port funct3, input, 3: instr[14:12] from the IR.
REQ-006 SHALL have port funct7b5, input, 1: instr[30] from the IR.
REQ-007 SHALL have port alu_zero, input, 1: ALU zero flag.
REQ-008 SHALL have port alu_lt, input, 1: signed rs1<rs2 flag.
REQ-009 SHALL have port mem_ack, input, 1: memory transfer-complete strobe.
REQ-010 SHALL have port mem_req, output, 1: memory request.
REQ-011 SHALL have port mem_we, output, 1: write qualifier, valid with mem_req.
REQ-012 SHALL have port ir_we, output, 1: IR load strobe.
REQ-013 SHALL have port pc_we, output, 1: PC load strobe.
REQ-014 SHALL have port pc_sel, output, 1: PC source, 0=pc+4, 1=pc+sext(imm).
REQ-015 SHALL have port rf_we, output, 1: register-file write strobe.
REQ-016 SHALL have port wb_sel, output, 2: write-back source, 0=ALU, 1=memory, 2=pc+4.
REQ-017 SHALL have port alu_src_imm, output, 1: ALU operand B source, 1=sext(imm), 0=rs2.
REQ-018 SHALL have port alu_op, output, 6: ALU operation code.
REQ-019 SHALL have port state, output, 3: current FSM state, for debug.
REQ-020 SHALL have port retire, output, 1: one-cycle pulse per completed instruction.
REQ-021 SHALL have port fault, output, 2: sticky fault code, 0=none, 1=illegal instruction, 2=bus timeout.

Function
REQ-022 SHALL implement the states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; encodings 6 and 7 SHALL go to HALT with fault=1.
REQ-023 SHALL assert mem_req with mem_we=0 in FETCH until the mem_ack cycle; that cycle SHALL pulse ir_we and move to DECODE.
REQ-024 SHALL treat mem_ack outside FETCH and MEM, or while mem_req=0, as ignored.
REQ-025 SHALL hold mem_req and mem_we stable while waiting; mem_req SHALL drop in the cycle after ack.
REQ-026 SHALL spend exactly one cycle in DECODE.
REQ-027 SHALL decode opcode in DECODE: 0110011 R, 0010011 I-ALU, 0000011 lw (funct3=010), 0100011 sw (funct3=010), 1100011 beq/blt (funct3 000/100), 1101111 jal; any other opcode/funct3 SHALL go to HALT with fault=1.
REQ-028 SHALL drive alu_op in EXEC and MEM as follows: add 000001, sub 000010, sll 000011, jal 000100, addi 000101, and 000110, or 000111, xor 001000, blt 001001, beq 001010, srl 001011, lw 001100, sw 001101; R funct3/funct7b5 picks add/sub/sll/and/or/xor/srl; I-ALU supports addi only, and other funct3 are illegal; alu_op SHALL be 000000 in all other states.
REQ-029 SHALL set alu_src_imm=1 for I-ALU, lw and sw.
REQ-030 SHALL resolve branches in EXEC: taken (beq&alu_zero or blt&alu_lt) means pc_we=1, pc_sel=1; not taken means pc_we=1, pc_sel=0; both cases pulse retire and go to FETCH.
REQ-031 SHALL go from EXEC to MEM for lw/sw, and to WB for R, I-ALU and jal.
REQ-032 SHALL, in MEM, assert mem_req with mem_we=1 for sw; on ack, sw SHALL pulse pc_we (pc_sel=0) and retire and go to FETCH, and lw SHALL go to WB.
REQ-033 SHALL, in WB, pulse rf_we; wb_sel SHALL be 0 for R/I, 1 for lw, 2 for jal; pc_we=1 with pc_sel=1 for jal, else 0; retire=1; next state FETCH.
REQ-034 SHALL count waiting cycles of a request with a counter that clears on every new request; reaching TIMEOUT without ack SHALL go to HALT with fault=2 and drop mem_req.
REQ-035 SHALL latch ack arriving in the same cycle the counter reaches TIMEOUT as success, not timeout.
REQ-036 SHALL hold HALT until reset; in HALT all strobes are 0, and pc_we, rf_we, ir_we and retire SHALL never assert.
REQ-037 SHALL pulse strobes (ir_we, pc_we, rf_we, retire) for at most one cycle per instruction.

Reset
REQ-038 SHALL, while rst_n=0, force state=FETCH, fault=0, timeout counter=0, and every output strobe and alu_op to 0 immediately, regardless of clk.
REQ-039 SHALL, on reset asserted mid-transfer, drop mem_req asynchronously; the first request after release is a fetch.
REQ-040 SHALL assert mem_req (fetch) in the first clk edge state after rst_n rises.

Verification
REQ-041 SHALL cover: add x3,x1,x2 (0x002081B3) with ack after 2 cycles -> states 0,0,0,1,2,4; alu_op=000001 in EXEC; rf_we,wb_sel=0,retire in WB.
REQ-042 SHALL cover: beq with alu_zero=1 -> pc_we=1, pc_sel=1, retire in EXEC, no rf_we; repeated with alu_zero=0 -> pc_sel=0.
REQ-043 SHALL cover: lw then sw with ack delay 3 each -> lw shows MEM alu_op=001100 then WB wb_sel=1; sw shows mem_we=1, no rf_we, retire on ack.
REQ-044 SHALL cover: opcode 0000000 -> HALT, fault=1, no strobes for 20 cycles, and mem_ack pulses ignored.
REQ-045 SHALL cover: TIMEOUT=4 with no ack -> HALT, fault=2 after 4 wait cycles; ack exactly on cycle 4 -> normal DECODE.
REQ-046 SHALL cover: rst_n low between clk edges during MEM -> mem_req=0 immediately; after release, fetch restarts with fault=0.
